mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage of the semiMIPS 5-stage pipeline, directly downstream of the EX/MEM register.
//  - Resolves branches/jumps: drives the PC redirect and the flush of younger stages.
//  - Performs data-memory load/store over a req/ready handshake, holding the pipeline during waits.
//  - Contains the MEM/WB pipeline register that feeds writeback.
// PARAMETERS
//  AWIDTH   32  address / PC width
//  DWIDTH   32  data width
//  TIMEOUT  16  max WAIT cycles before a memory access is abandoned (>=2)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  memwr        in   1       store request (EX/MEM)
//  memrd        in   1       load request (EX/MEM)
//  bbne         in   1       branch flag (EX/MEM)
//  bbeq         in   1       branch flag (EX/MEM)
//  bblez        in   1       branch flag (EX/MEM)
//  bbgtz        in   1       branch flag (EX/MEM)
//  jump         in   1       jump flag (EX/MEM)
//  memtoreg     in   2       writeback select: 00 ALU, 01 mem data, 10 pcnext
//  regwr        in   1       register write enable
//  aluout       in   DWIDTH  ALU result; effective address for loads/stores
//  zero         in   1       ALU flag
//  negative     in   1       ALU flag
//  regdstmux    in   5       destination register
//  regdata2     in   DWIDTH  store data
//  branaddr     in   AWIDTH  branch target
//  jmpaddr      in   AWIDTH  jump target
//  pcnext       in   AWIDTH  PC+4
//  dmem_req     out  1       memory request
//  dmem_we      out  1       1 = write
//  dmem_addr    out  AWIDTH  word-aligned address = aluout
//  dmem_wdata   out  DWIDTH  = regdata2
//  dmem_ready   in   1       access complete (may be same cycle as req)
//  dmem_rdata   in   DWIDTH  load data, valid when dmem_ready
//  pcsrc        out  1       redirect PC to pctarget
//  pctarget     out  AWIDTH  redirect target
//  flush        out  1       squash IF/ID, ID/EX, EX/MEM
//  stall        out  1       freeze PC through EX/MEM this cycle
//  memerr       out  1       one-cycle pulse: misaligned address or timeout
//  wb_memtoreg  out  2       MEM/WB register output
//  wb_regwr     out  1       MEM/WB register output
//  wb_aluout    out  DWIDTH  MEM/WB register output
//  wb_memdata   out  DWIDTH  MEM/WB register output
//  wb_regdst    out  5       MEM/WB register output
//  wb_pcnext    out  AWIDTH  MEM/WB register output
// BEHAVIOUR
//  Reset: rst wins over all other inputs.
//    - FSM -> IDLE, wait counter = 0.
//    - All registered outputs and memerr = 0; all wb_* = 0 (a bubble).
//  Branch resolution (combinational, same cycle):
//    - taken = (bbeq&zero) | (bbne&~zero) | (bblez&(negative|zero)) | (bbgtz&~negative&~zero).
//    - jump has priority over taken: pctarget = jump ? jmpaddr : branaddr.
//    - pcsrc = flush = jump | taken. Never asserted while stall=1.
//  Memory access: acc = memrd | memwr.
//    - Misaligned (aluout[1:0] != 0): no request; memerr pulses; op completes with memdata = 0.
//    - If memrd and memwr are both set, memwr takes precedence.
//    - dmem_req = acc & aligned & (IDLE | WAIT); dmem_we = memwr.
//    - Address and write data are held stable while in WAIT.
//  FSM states: IDLE, WAIT.
//    - IDLE: if acc & aligned & ~dmem_ready -> WAIT, counter = 1. Otherwise stay.
//    - WAIT, dmem_ready = 1 -> IDLE.
//    - WAIT, counter == TIMEOUT-1 -> IDLE; memerr pulses; memdata = 0.
//    - WAIT, otherwise: counter++.
//    - stall = acc & aligned & ~dmem_ready & ~(WAIT & counter == TIMEOUT-1).
//    - Zero-wait memory: no stall, latency 0.
//  MEM/WB register (posedge clk):
//    - stall = 1: load a bubble (regwr = 0, memtoreg = 00, other wb_* hold value).
//    - Otherwise: capture inputs; wb_memdata = dmem_rdata on a completed load, else 0.
//    - Latency input -> wb_* is 1 cycle after completion.
//  Reset mid-WAIT: dmem_req drops in the cycle after rst; the pending access is abandoned.
// STRUCTURE
//  - Shared package semimips_pkg: memtoreg encodings (MTR_ALU / MTR_MEM / MTR_PC) and FSM state enum.
//  - One sub-module: mem_branch_resolve (flags + targets -> pcsrc, pctarget).
//  - FSM, counter and MEM/WB register stay inline in this module.
// TESTING
//  1. ALU op regwr=1, aluout=0x1234 -> next cycle wb_aluout=0x1234, wb_regwr=1; stall and dmem_req never set.
//  2. Load aluout=0x100, dmem_ready same cycle, rdata=0xDEADBEEF -> stall=0; next cycle wb_memdata=0xDEADBEEF.
//  3. Store, ready after 3 cycles -> stall=1 for 3 cycles with wb_regwr=0 bubbles; addr/wdata stable; dmem_we=1.
//  4. beq with zero=1, branaddr=0x40 -> pcsrc=flush=1, pctarget=0x40; with zero=0 -> pcsrc=0.
//     Repeat for bne, blez, bgtz using negative=1/zero=0 combinations.
//  5. jump and bbeq&zero both set -> pctarget=jmpaddr.
//  6. Load never ready -> stall for TIMEOUT-1 cycles, then memerr pulse and wb_memdata=0.
//     rst asserted mid-WAIT -> IDLE, dmem_req=0 next cycle.
//  7. Misaligned load aluout=0x102 -> memerr=1 same cycle, dmem_req=0, no stall.

Source files
------------

// File: rtl/semimips_pkg.sv
// Shared semiMIPS definitions: writeback-select encodings, memory-stage FSM states
// and a small address helper.
package semimips_pkg;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC  = 2'b10
  } memtoreg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_branch_resolve.sv
// Branch/jump resolution for the memory stage: ALU flags and branch kind give the
// redirect request and its target; jump takes priority over a taken branch.
module mem_branch_resolve #(
  parameter int AWIDTH = 32
) (
  input  logic              i_bbeq,
  input  logic              i_bbne,
  input  logic              i_bblez,
  input  logic              i_bbgtz,
  input  logic              i_jump,
  input  logic              i_zero,
  input  logic              i_negative,
  input  logic [AWIDTH-1:0] i_branaddr,
  input  logic [AWIDTH-1:0] i_jmpaddr,
  output logic              o_redirect,
  output logic [AWIDTH-1:0] o_pctarget
);

  logic w_taken;

  assign w_taken = (i_bbeq  &  i_zero)
                 | (i_bbne  & ~i_zero)
                 | (i_bblez & (i_negative | i_zero))
                 | (i_bbgtz & ~i_negative & ~i_zero);

  assign o_redirect = i_jump | w_taken;
  assign o_pctarget = i_jump ? i_jmpaddr : i_branaddr;

endmodule

// File: rtl/mem_stage.sv
// semiMIPS memory stage: branch redirect, data-memory access over req/ready with
// wait-state timeout, and the MEM/WB pipeline register.
module mem_stage
  import semimips_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwr,
  input  logic              memrd,
  input  logic              bbne,
  input  logic              bbeq,
  input  logic              bblez,
  input  logic              bbgtz,
  input  logic              jump,
  input  logic [1:0]        memtoreg,
  input  logic              regwr,
  input  logic [DWIDTH-1:0] aluout,
  input  logic              zero,
  input  logic              negative,
  input  logic [4:0]        regdstmux,
  input  logic [DWIDTH-1:0] regdata2,
  input  logic [AWIDTH-1:0] branaddr,
  input  logic [AWIDTH-1:0] jmpaddr,
  input  logic [AWIDTH-1:0] pcnext,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic              pcsrc,
  output logic [AWIDTH-1:0] pctarget,
  output logic              flush,
  output logic              stall,
  output logic              memerr,
  output logic [1:0]        wb_memtoreg,
  output logic              wb_regwr,
  output logic [DWIDTH-1:0] wb_aluout,
  output logic [DWIDTH-1:0] wb_memdata,
  output logic [4:0]        wb_regdst,
  output logic [AWIDTH-1:0] wb_pcnext
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_we;

  logic w_acc;
  logic w_aligned;
  logic w_go;
  logic w_in_wait;
  logic w_last;
  logic w_timeout;
  logic w_misalign;
  logic w_load_done;
  logic w_redirect;

  mem_branch_resolve #(
    .AWIDTH (AWIDTH)
  ) u_branch (
    .i_bbeq     (bbeq),
    .i_bbne     (bbne),
    .i_bblez    (bblez),
    .i_bbgtz    (bbgtz),
    .i_jump     (jump),
    .i_zero     (zero),
    .i_negative (negative),
    .i_branaddr (branaddr),
    .i_jmpaddr  (jmpaddr),
    .o_redirect (w_redirect),
    .o_pctarget (pctarget)
  );

  assign w_acc       = memrd | memwr;
  assign w_aligned   = word_aligned(aluout[1:0]);
  // Reset overrides the live request so an abandoned access never reaches memory.
  assign w_go        = ~rst & w_acc & w_aligned;
  assign w_misalign  = ~rst & w_acc & ~w_aligned;
  assign w_in_wait   = (r_state == ST_WAIT);
  assign w_last      = w_in_wait && (r_cnt == CNT_LAST);
  assign w_timeout   = w_go & w_last & ~dmem_ready;
  assign w_load_done = w_go & memrd & ~memwr & dmem_ready;

  assign stall    = w_go & ~dmem_ready & ~w_last;
  assign memerr   = w_misalign | w_timeout;
  assign pcsrc    = w_redirect & ~stall;
  assign flush    = pcsrc;

  assign dmem_req   = w_go;
  assign dmem_we    = w_in_wait ? r_we    : memwr;
  assign dmem_addr  = w_in_wait ? r_addr  : aluout[AWIDTH-1:0];
  assign dmem_wdata = w_in_wait ? r_wdata : regdata2;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go && !dmem_ready) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(1);
            r_addr  <= aluout[AWIDTH-1:0];
            r_wdata <= regdata2;
            r_we    <= memwr;
          end
        end
        ST_WAIT: begin
          if (!w_go || dmem_ready || w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // While stalled only the control fields become a bubble; the data fields keep
  // their last value since nothing downstream consumes them without regwr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_memtoreg <= MTR_ALU;
      wb_regwr    <= 1'b0;
      wb_aluout   <= '0;
      wb_memdata  <= '0;
      wb_regdst   <= '0;
      wb_pcnext   <= '0;
    end else if (stall) begin
      wb_memtoreg <= MTR_ALU;
      wb_regwr    <= 1'b0;
    end else begin
      wb_memtoreg <= memtoreg;
      wb_regwr    <= regwr;
      wb_aluout   <= aluout;
      wb_memdata  <= w_load_done ? dmem_rdata : '0;
      wb_regdst   <= regdstmux;
      wb_pcnext   <= pcnext;
    end
  end

endmodule
